win_max_sat: RTL
================

// Module: win_max_sat
// PURPOSE
//  Streaming window peak detector: accepts unsigned U(7,0) samples over a valid/ready input,
//  takes max of every N consecutive samples, saturated at SAT (default 200), emits one result per window.
//  Sequential, stream-side counterpart of the combinational max/saturate datapath.
//  Sits between a sample source and any consumer that needs clipped peak values.
// PARAMETERS
//  W     8    sample and result width, unsigned
//  SAT   200  saturation ceiling; must satisfy SAT <= 2**W-1
//  N     4    samples per window, N >= 1
//  CW    $clog2(N+1)  window counter width (localparam, derived)
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  synchronous reset, active high
//  clear      in   1  synchronous abort of the current window (no output produced)
//  in_valid   in   1  input sample valid
//  in_ready   out  1  block can accept a sample
//  in_data    in   W  sample, unsigned
//  out_valid  out  1  window result valid
//  out_ready  in   1  consumer accepts result
//  out_max    out  W  saturated window maximum
//  out_sat    out  1  (SAT_FLAG_EN only) some sample in window was > SAT
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. All state updates on posedge clk.
//  - Reset values: state=ACC, cnt=0, acc=0, out_valid=0, out_max=0, out_sat=0; in_ready=1 the cycle after.
//  - Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
//  - States: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
//  - Per accepted sample: s = (in_data > SAT) ? SAT : in_data;
//    acc <= (cnt==0) ? s : max(acc, s); cnt <= cnt+1. Comparisons unsigned, no width growth.
//  - When Nth sample accepted: out_max <= max result, cnt <= 0, state -> HOLD.
//    out_valid rises the cycle after the Nth transfer (latency 1).
//  - HOLD: out_max/out_sat stable until out_ready; on transfer -> ACC, out_valid falls next cycle.
//    No input bypass: HOLD never accepts (no bubble-free overlap; throughput N+1 cycles min).
//  - Sample exactly == SAT is passed unchanged, not counted as saturation.
//  - clear in ACC: cnt<=0, acc<=0, partial window discarded; a sample presented the same cycle
//    is NOT accepted (in_ready forced 0 while clear=1).
//  - clear in HOLD: ignored; pending result still delivered. rst overrides clear and all transfers.
//  - Reset mid-window or mid-HOLD: pending data lost, no out_valid pulse afterward.
//  - in_valid low cycles inside a window: no state change (gaps allowed).
// CONFIGURATION
//  - Macro SAT_FLAG_EN defined: out_sat port present; sticky flag per window set when any
//    accepted raw sample > SAT, cleared at window start, by clear and by rst; registered with out_max.
//  - Not defined: out_sat port and flag logic absent; all other behaviour identical.
// STRUCTURE
//  - Package win_max_pkg: default W/SAT/N constants, state enum {ACC, HOLD} typedef.
//  - Sub-module sat_max2 (combinational): inputs a,b (W), param SAT; y = min(max(a,b), SAT).
//    Used once for the accumulator update; top holds FSM, counter and output registers.
// TESTING
//  - rst high 2 cycles -> out_valid=0, out_max=0, in_ready=1 after release.
//  - N=4 samples 10,50,30,20 with out_ready=1 -> out_max=50 one cycle after 4th, out_sat=0.
//  - samples 199,200,201,5 -> out_max=200, out_sat=1 (flag from 201 only); 200,200,0,0 -> out_sat=0.
//  - out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, out_max stable, no sample lost.
//  - 2 samples (90,120) then clear, then 3,4,5,6 -> single result out_max=6, no result for 120.
//  - rst asserted in HOLD with out_ready=0 -> out_valid=0 next cycle, next window starts clean.

Source files
------------

// File: rtl/win_max_pkg.sv
// Shared constants and state type for the windowed peak detector.
// Optional feature macro used across the slice: SAT_FLAG_EN.
package win_max_pkg;
  localparam int W_DEF   = 8;
  localparam int SAT_DEF = 200;
  localparam int N_DEF   = 4;

  typedef enum logic {ACC, HOLD} state_t;
endpackage

// File: rtl/win_max_sat_if.sv
// Sample-in / result-out stream bundle for win_max_sat.
// out_sat is only present when SAT_FLAG_EN is defined.
interface win_max_sat_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_max;
`ifdef SAT_FLAG_EN
  logic         out_sat;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_max, out_sat);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_max, out_sat);
`else
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_max);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_max);
`endif
endinterface

// File: rtl/sat_max2.sv
// Combinational two-input maximum clipped to a ceiling: y = min(max(a,b), SAT).
module sat_max2 #(
  parameter int W   = 8,
  parameter int SAT = 200
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  localparam logic [W-1:0] SAT_V = W'(SAT);

  logic [W-1:0] m;

  always_comb begin
    m = (a > b) ? a : b;
    y = (m > SAT_V) ? SAT_V : m;
  end
endmodule

// File: rtl/win_max_sat.sv
// Streaming window peak detector: max of every N accepted samples, clipped at SAT.
// Define SAT_FLAG_EN to add the per-window out_sat flag.
module win_max_sat
  import win_max_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int SAT = SAT_DEF,
  parameter int N   = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  win_max_sat_if.slave bus
);
  localparam int             CW    = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST  = CW'(N - 1);
  localparam logic [W-1:0]   SAT_V = W'(SAT);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic [W-1:0]  acc_reg;
  logic [W-1:0]  out_max_reg;
  logic [W-1:0]  acc_base;
  logic [W-1:0]  acc_next;
  logic          in_ready_c;
  logic          out_valid_c;
  logic          take;
  logic          last;

  // First sample of a window must not be compared against a stale accumulator.
  assign acc_base = (cnt_reg == '0) ? '0 : acc_reg;
  assign last     = (cnt_reg == LAST);

  sat_max2 #(.W(W), .SAT(SAT)) u_sat_max2 (
    .a (acc_base),
    .b (bus.in_data),
    .y (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ACC;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    take        = 1'b0;
    case (state_reg)
      ACC: begin
        in_ready_c = ~clear;
        take       = bus.in_valid & in_ready_c;
        if (take && last) state_next = HOLD;
      end
      HOLD: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      acc_reg     <= '0;
      out_max_reg <= '0;
    end else if (state_reg == ACC && clear) begin
      cnt_reg <= '0;
      acc_reg <= '0;
    end else if (take) begin
      acc_reg <= acc_next;
      if (last) begin
        cnt_reg     <= '0;
        out_max_reg <= acc_next;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

`ifdef SAT_FLAG_EN
  logic flag_reg;
  logic flag_next;
  logic out_sat_reg;

  // Only raw samples strictly above the ceiling count; equal-to-ceiling passes clean.
  assign flag_next = ((cnt_reg == '0) ? 1'b0 : flag_reg) | (bus.in_data > SAT_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_reg    <= 1'b0;
      out_sat_reg <= 1'b0;
    end else if (state_reg == ACC && clear) begin
      flag_reg <= 1'b0;
    end else if (take) begin
      flag_reg <= flag_next;
      if (last) out_sat_reg <= flag_next;
    end
  end

  assign bus.out_sat = out_sat_reg;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_max   = out_max_reg;
endmodule
